// File: rtl/foc_pi_pkg.sv
// Shared widths, anti-windup limits and fixed-point helpers for the FOC current PI loop.
// The clamp and rounding helpers are common to the proportional and integral paths.
package foc_pi_pkg;
    localparam int PROD_W = 30;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 14;

    // Accumulator limits are the output range scaled back up by the dropped fraction bits.
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2**(OUT_W-1) - 1) * (2**SHIFT));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2**(OUT_W-1+SHIFT)));

    function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = {ACC_MAX[ACC_W-1], ACC_MAX};
        lo = {ACC_MIN[ACC_W-1], ACC_MIN};
        if (x > hi) return ACC_MAX;
        if (x < lo) return ACC_MIN;
        return x[ACC_W-1:0];
    endfunction

    // Round half up, then arithmetic shift; callers guarantee the result fits OUT_W.
    function automatic logic signed [OUT_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + (ACC_W+1)'(2**(SHIFT-1));
        return t[SHIFT +: OUT_W];
    endfunction
endpackage

// File: rtl/foc_valid_pipe.sv
// Valid tracker for a ce-gated multiplier: DEPTH ce-qualified edges from in_vld to out_vld.
// Holds while ce=0; clr empties the pipe and overrides ce.
module foc_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    input  logic in_vld,
    output logic out_vld
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end else if (ce) begin
            vld_d = (vld_q << 1) | DEPTH'(in_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
endmodule

// File: rtl/foc_pi_integrator.sv
// Integral path: paces the Ki x error multiplier, accumulates products into a clamped integrator.
// Result MUL_LATENCY+1 cycles after operand accept; an unaccepted result freezes multiplier, valid pipe and acc.
module foc_pi_integrator #(
    parameter int MUL_LATENCY = 3,
    parameter int PROD_W      = foc_pi_pkg::PROD_W,
    parameter int ACC_W       = foc_pi_pkg::ACC_W,
    parameter int OUT_W       = foc_pi_pkg::OUT_W,
    parameter int SHIFT       = foc_pi_pkg::SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mul_ce,
    input  logic signed [PROD_W-1:0] mul_p,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);
    import foc_pi_pkg::*;

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_clamped;
    logic signed [ACC_W:0]   sum;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sat_q, out_sat_d;
    logic                    stall, xfer, prod_vld, update, clamp_hit;

    assign stall    = out_valid_q & ~out_ready;
    assign mul_ce   = ~stall;
    assign in_ready = mul_ce & ~clear;
    assign xfer     = in_valid & in_ready;

    foc_valid_pipe #(.DEPTH(MUL_LATENCY)) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (mul_ce),
        .clr     (clear),
        .in_vld  (xfer),
        .out_vld (prod_vld)
    );

    assign update = prod_vld & mul_ce & ~clear;

    // One guard bit so the clamp sees the true sum before it wraps.
    assign sum         = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){mul_p[PROD_W-1]}}, mul_p};
    assign acc_clamped = clamp_acc(sum);
    assign clamp_hit   = (sum != {acc_clamped[ACC_W-1], acc_clamped});

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (clear) begin
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_sat_d   = 1'b0;
        end else if (update) begin
            acc_d       = acc_clamped;
            out_sat_d   = clamp_hit;
            out_data_d  = round_shift(acc_clamped);
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_foc_pi_integrator.sv
// Bench for foc_pi_integrator: vector table, stall/clear/reset sequences, then random traffic
// scored against a running-sum model of the integrator.
module tb_foc_pi_integrator;
    import foc_pi_pkg::*;

    localparam int     LAT  = 3;
    localparam longint MAXV = 64'sd32767 * 64'sd16384;
    localparam longint MINV = -64'sd32768 * 64'sd16384;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, mul_ce, clear, out_valid, out_ready, out_sat;
    logic signed [PROD_W-1:0] mul_p, in_prod;
    logic signed [OUT_W-1:0]  out_data;
    logic signed [PROD_W-1:0] mpipe [LAT];

    int     errors = 0;
    int     checks = 0;
    longint q[$];
    longint m_acc = 0;
    bit     xfer_last = 1'b0;

    typedef struct {
        bit     do_clear;
        longint prod;
        longint exp_data;
        bit     exp_sat;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    // Stand-in for the external multiplier: product of accepted operands after LAT ce edges.
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= in_prod;
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_p = mpipe[LAT-1];

    foc_pi_integrator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_ce    (mul_ce),
        .mul_p     (mul_p),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic longint round_model(input longint a);
        longint t, qv;
        t  = a + 8192;
        qv = t / 16384;
        if ((t % 16384) != 0 && t < 0) qv = qv - 1;
        return qv;
    endfunction

    // Scoreboard step, evaluated mid-cycle on the values the next edge will act on.
    task automatic sample();
        longint p;
        bit     sat;
        xfer_last = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_acc = 0;
            return;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: result %0d delivered with nothing outstanding", out_data);
            end else begin
                p     = q.pop_front();
                m_acc = m_acc + p;
                sat   = 1'b0;
                if (m_acc > MAXV) begin
                    m_acc = MAXV;
                    sat   = 1'b1;
                end else if (m_acc < MINV) begin
                    m_acc = MINV;
                    sat   = 1'b1;
                end
                chk("sb_data", out_data, round_model(m_acc));
                chk("sb_sat", out_sat, sat);
            end
        end
        if (clear) begin
            q.delete();
            m_acc = 0;
        end else if (in_valid && in_ready) begin
            q.push_back(in_prod);
            xfer_last = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        chk("clear_in_ready", in_ready, 0);
        tick();
        clear = 1'b0;
    endtask

    task automatic send(input longint p);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_prod  = PROD_W'(p);
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic expect_out(input string name, input longint d, input bit s, input int want_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_lat"}, lat, want_lat);
        chk({name, "_data"}, out_data, d);
        chk({name, "_sat"}, out_sat, s);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        bit     seen;
        longint p;

        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; clear = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_mul_ce", mul_ce, 1);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        vecs[0] = '{1'b0, 16384, 1, 1'b0};
        vecs[1] = '{1'b1, 8192, 1, 1'b0};
        vecs[2] = '{1'b1, 8191, 0, 1'b0};
        vecs[3] = '{1'b1, -8192, 0, 1'b0};
        vecs[4] = '{1'b1, -8193, -1, 1'b0};
        vecs[5] = '{1'b1, 300000000, 18311, 1'b0};
        vecs[6] = '{1'b0, 300000000, 32767, 1'b1};
        vecs[7] = '{1'b0, -16384, 32766, 1'b0};
        vecs[8] = '{1'b1, -300000000, -18311, 1'b0};
        vecs[9] = '{1'b0, -300000000, -32768, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_clear) pulse_clear();
            send(vecs[i].prod);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_sat, LAT);
            tick();
        end

        // Back-to-back products with the first result held for 5 cycles.
        pulse_clear();
        in_valid = 1'b1;
        in_prod  = PROD_W'(16384);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b2b_accept", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        expect_out("b2b_first", 1, 1'b0, 1);
        out_ready = 1'b0;
        #1;
        chk("stall_mul_ce", mul_ce, 0);
        chk("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("b2b_valid%0d", k), out_valid, 1);
            chk($sformatf("b2b_data%0d", k), out_data, k);
            tick();
        end
        chk("b2b_done", out_valid, 0);

        // Clear with two products in flight.
        pulse_clear();
        in_valid = 1'b1;
        in_prod  = PROD_W'(5 * 16384);
        tick();
        tick();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen |= out_valid;
            tick();
        end
        chk("clr_no_out", seen, 0);
        send(16384);
        expect_out("clr_next", 1, 1'b0, LAT);
        tick();

        // Asynchronous reset in the middle of a stream.
        pulse_clear();
        in_valid = 1'b1;
        in_prod  = PROD_W'(16384);
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sat", out_sat, 0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        send(32768);
        expect_out("post_rst", 2, 1'b0, LAT);
        tick();

        // Random traffic with backpressure and occasional clears.
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || xfer_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0)
                    p = longint'($urandom_range(0, 1 << 29)) - (64'sd1 << 28);
                else
                    p = longint'($urandom_range(0, 1 << 21)) - (64'sd1 << 20);
                in_prod = PROD_W'(p);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("sb_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
